// File: rtl/lkahd_adder_checker_pkg.sv
// Shared types for the lookahead-adder response checker: FSM states, counter width
// and the operand sample carried through the alignment delay line.
package lkahd_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int VCNT_W    = 16;
    // Operand fields are sized for the widest adder this checker is expected to watch.
    localparam int SMP_MAX_W = 16;

    // valid is the last field so it lands in bit 0 of the packed sample.
    typedef struct packed {
        logic [SMP_MAX_W-1:0] x;
        logic [SMP_MAX_W-1:0] y;
        logic                 cin;
        logic                 valid;
    } sample_t;

    function automatic logic [SMP_MAX_W:0] sample_sum(input sample_t s);
        return {1'b0, s.x} + {1'b0, s.y} + {{SMP_MAX_W{1'b0}}, s.cin};
    endfunction

endpackage

// File: rtl/lkahd_adder_checker_delay_line.sv
// Fixed-depth shift register of operand samples; bit 0 of each entry is its valid flag,
// the only bit that is reset or cleared. DEPTH=0 is a plain pass-through.
module chk_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] out_data
);

    if (DEPTH == 0) begin : g_pass
        assign out_data = {in_data[DW-1:1], in_data[0] & ~clr};
    end else begin : g_shift
        logic [DEPTH-1:0] vld_q;
        logic [DEPTH-1:0] vld_d;
        logic [DW-2:0]    dat_q [DEPTH];
        logic [DW-2:0]    dat_d [DEPTH];

        always_comb begin
            vld_d[0] = in_data[0] & ~clr;
            dat_d[0] = in_data[DW-1:1];
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1] & ~clr;
                dat_d[i] = dat_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d;
            end
        end

        // Payload never needs a reset: it is ignored whenever its valid bit is low.
        always_ff @(posedge clk) begin
            dat_q <= dat_d;
        end

        assign out_data = {dat_q[DEPTH-1], vld_q[DEPTH-1]};
    end

endmodule

// File: rtl/lkahd_adder_checker.sv
// Response monitor for a lookahead adder: aligns operands with the adder's results,
// compares against x+y+cin, counts vectors/mismatches and captures the first failure.
module lkahd_adder_checker
    import lkahd_chk_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int LATENCY  = 0,
    parameter int NUM_VECT = 128,
    parameter int ERRW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              valid_in,
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic              cin,
    input  logic [WIDTH-1:0]  sum,
    input  logic              cout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [VCNT_W-1:0] vec_cnt,
    output logic [ERRW-1:0]   err_cnt,
    output logic              err_flag,
    output logic [WIDTH-1:0]  first_x,
    output logic [WIDTH-1:0]  first_y,
    output logic              first_cin,
    output logic [WIDTH-1:0]  first_sum,
    output logic              first_cout
);

    localparam int              ACC_W      = VCNT_W + 1;
    localparam logic [ACC_W-1:0] NV        = ACC_W'(NUM_VECT);
    localparam logic [3:0]      DRAIN_LAST = 4'(LATENCY);

    function automatic logic [VCNT_W-1:0] sat_inc_vcnt(input logic [VCNT_W-1:0] v);
        return (&v) ? v : v + VCNT_W'(1);
    endfunction

    function automatic logic [ERRW-1:0] sat_inc_err(input logic [ERRW-1:0] v);
        return (&v) ? v : v + ERRW'(1);
    endfunction

    function automatic logic [ACC_W-1:0] sat_inc_acc(input logic [ACC_W-1:0] v);
        return (&v) ? v : v + ACC_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         drain_cnt_q, drain_cnt_d;
    logic [ACC_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [VCNT_W-1:0]  vec_cnt_q, vec_cnt_d;
    logic [ERRW-1:0]    err_cnt_q, err_cnt_d;
    logic               err_flag_q, err_flag_d;
    logic [WIDTH-1:0]   first_x_q, first_x_d;
    logic [WIDTH-1:0]   first_y_q, first_y_d;
    logic               first_cin_q, first_cin_d;
    logic [WIDTH-1:0]   first_sum_q, first_sum_d;
    logic               first_cout_q, first_cout_d;

    logic               accept;
    logic               mismatch;
    sample_t            push;
    sample_t            pop;

    // ---- accept stage: only RUN takes operands, and never on a restart edge
    assign accept = valid_in && (state_q == RUN) && !start &&
                    ((NV == '0) || (acc_cnt_q < NV));

    always_comb begin
        push       = '0;
        push.x     = SMP_MAX_W'(x);
        push.y     = SMP_MAX_W'(y);
        push.cin   = cin;
        push.valid = accept;
    end

    if (LATENCY == 0) begin : g_comb
        assign pop = push;
    end else begin : g_dly
        chk_delay_line #(
            .DEPTH (LATENCY),
            .DW    ($bits(sample_t))
        ) u_dly (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (start),
            .in_data  (push),
            .out_data (pop)
        );
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        acc_cnt_d   = accept ? sat_inc_acc(acc_cnt_q) : acc_cnt_q;
        if (start) begin
            state_d     = RUN;
            acc_cnt_d   = '0;
            drain_cnt_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (stop || ((NV != '0) && (acc_cnt_d == NV))) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
                // Hold long enough for the last accepted sample to reach the result registers.
                DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- compare stage: aligned operands against the adder's sum/cout
    // Operands are below 2**WIDTH, so comparing the full-width sum is exact.
    assign mismatch = pop.valid &&
                      (sample_sum(pop) != (SMP_MAX_W + 1)'({cout, sum}));

    always_comb begin
        vec_cnt_d    = vec_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_flag_d   = err_flag_q;
        first_x_d    = first_x_q;
        first_y_d    = first_y_q;
        first_cin_d  = first_cin_q;
        first_sum_d  = first_sum_q;
        first_cout_d = first_cout_q;
        if (start) begin
            vec_cnt_d    = '0;
            err_cnt_d    = '0;
            err_flag_d   = 1'b0;
            first_x_d    = '0;
            first_y_d    = '0;
            first_cin_d  = 1'b0;
            first_sum_d  = '0;
            first_cout_d = 1'b0;
        end else if (pop.valid) begin
            vec_cnt_d = sat_inc_vcnt(vec_cnt_q);
            if (mismatch) begin
                err_cnt_d  = sat_inc_err(err_cnt_q);
                err_flag_d = 1'b1;
                if (!err_flag_q) begin
                    first_x_d    = pop.x[WIDTH-1:0];
                    first_y_d    = pop.y[WIDTH-1:0];
                    first_cin_d  = pop.cin;
                    first_sum_d  = sum;
                    first_cout_d = cout;
                end
            end
        end
        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_cnt_d == '0);
    end

    // ---- result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            drain_cnt_q  <= '0;
            acc_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            vec_cnt_q    <= '0;
            err_cnt_q    <= '0;
            err_flag_q   <= 1'b0;
            first_x_q    <= '0;
            first_y_q    <= '0;
            first_cin_q  <= 1'b0;
            first_sum_q  <= '0;
            first_cout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            vec_cnt_q    <= vec_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_flag_q   <= err_flag_d;
            first_x_q    <= first_x_d;
            first_y_q    <= first_y_d;
            first_cin_q  <= first_cin_d;
            first_sum_q  <= first_sum_d;
            first_cout_q <= first_cout_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign vec_cnt    = vec_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign err_flag   = err_flag_q;
    assign first_x    = first_x_q;
    assign first_y    = first_y_q;
    assign first_cin  = first_cin_q;
    assign first_sum  = first_sum_q;
    assign first_cout = first_cout_q;

endmodule
